// File: rtl/spc_pkg.sv
// Shared definitions for the SPC return-stack controller: word/pointer sizes,
// command op codes and the controller FSM state encoding.
package spc_pkg;

  localparam int SPC_DW = 19;
  localparam int SPC_AW = 5;

  typedef enum logic [1:0] {
    OP_PEEK    = 2'b00,
    OP_PUSH    = 2'b01,
    OP_POP     = 2'b10,
    OP_REPLACE = 2'b11
  } spc_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WR    = 2'b01,
    ST_RD    = 2'b10,
    ST_FETCH = 2'b11
  } spc_state_e;

  // PUSH and REPLACE use the stack write port; PEEK and POP use the read port.
  function automatic logic op_is_write(spc_op_e op);
    return (op == OP_PUSH) || (op == OP_REPLACE);
  endfunction

  function automatic logic op_is_read(spc_op_e op);
    return (op == OP_POP) || (op == OP_PEEK);
  endfunction

endpackage

// File: rtl/spc_stack_ctl_if.sv
// Command/response handshake toward the microsequencer plus the strobe/data
// lines toward the SPC stack block. slave = controller side, master = user side.
interface spc_stack_ctl_if #(
  parameter int DW = spc_pkg::SPC_DW
);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;

  logic          spc_spcnt;
  logic          spc_spush;
  logic          spc_srp;
  logic          spc_swp;
  logic          spc_fetch;
  logic [DW-1:0] spc_wdata;
  logic [DW-1:0] spc_rdata;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_data,
    output spc_spcnt, spc_spush, spc_srp, spc_swp, spc_fetch, spc_wdata,
    input  spc_rdata
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data,
    input  spc_spcnt, spc_spush, spc_srp, spc_swp, spc_fetch, spc_wdata,
    output spc_rdata
  );

endinterface

// File: rtl/spc_depth_ctr.sv
// Saturating up/down occupancy counter for the SPC stack; reports depth,
// empty and full. Depth is AW+1 bits wide so a completely full stack is representable.
module spc_depth_ctr
  import spc_pkg::*;
#(
  parameter int AW = SPC_AW
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        dec,
  output logic [AW:0] depth,
  output logic        empty,
  output logic        full
);

  localparam logic [AW:0] CAPACITY = {1'b1, {AW{1'b0}}};

  // Saturate at both ends: overflowing pushes overwrite old entries and must not
  // make the count wrap back to a small value.
  always_ff @(posedge clk) begin
    if (reset) begin
      depth <= '0;
    end else if (inc && !dec && (depth != CAPACITY)) begin
      depth <= depth + 1'b1;
    end else if (dec && !inc && (depth != '0)) begin
      depth <= depth - 1'b1;
    end
  end

  assign empty = (depth == '0);
  assign full  = (depth == CAPACITY);

endmodule

// File: rtl/spc_stack_ctl.sv
// Command-side controller for the 32-entry SPC return stack: FSM, strobe decode
// and response register. Optional trap build selected by the SPC_TRAP_EN macro.
module spc_stack_ctl
  import spc_pkg::*;
#(
  parameter int DW = SPC_DW,
  parameter int AW = SPC_AW
) (
  input  logic            clk,
  input  logic            reset,
  spc_stack_ctl_if.slave  bus,
  output logic [AW:0]     depth,
  output logic            empty,
  output logic            full,
  output logic            trap_ovf,
  output logic            trap_unf
);

  spc_state_e    state_q;
  spc_state_e    state_d;
  spc_op_e       op_q;
  spc_op_e       cmd_op;
  logic          supp_q;
  logic          supp_cmd;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rsp_data_q;
  logic          rsp_valid_q;
  logic          accept;

  logic          ready_c;
  logic          spcnt_c;
  logic          spush_c;
  logic          srp_c;
  logic          swp_c;
  logic          fetch_c;
  logic          rsp_fire;
  logic          dep_inc;
  logic          dep_dec;

  assign cmd_op = spc_op_e'(bus.cmd_op);
  assign accept = bus.cmd_valid && bus.cmd_ready;

`ifdef SPC_TRAP_EN
  assign supp_cmd = ((cmd_op == OP_PUSH) && full) || (op_is_read(cmd_op) && empty);
`else
  assign supp_cmd = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_PEEK;
      supp_q      <= 1'b0;
      wdata_q     <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_fire;
      if (rsp_fire) begin
        rsp_data_q <= bus.spc_rdata;
      end
      if (accept) begin
        op_q   <= cmd_op;
        supp_q <= supp_cmd;
        if (op_is_write(cmd_op)) begin
          wdata_q <= bus.cmd_data;
        end
      end
    end
  end

  // A suppressed (trapped) command still walks ACC/FETCH so the command rate
  // stays fixed, but every stack strobe and the depth update are masked.
  always_comb begin
    state_d  = state_q;
    ready_c  = 1'b0;
    spcnt_c  = 1'b0;
    spush_c  = 1'b0;
    srp_c    = 1'b0;
    swp_c    = 1'b0;
    fetch_c  = 1'b0;
    rsp_fire = 1'b0;
    dep_inc  = 1'b0;
    dep_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_c = 1'b1;
        if (bus.cmd_valid) begin
          state_d = op_is_write(cmd_op) ? ST_WR : ST_RD;
        end
      end
      ST_WR: begin
        state_d = ST_FETCH;
        if (!supp_q) begin
          swp_c = 1'b1;
          if (op_q == OP_PUSH) begin
            spcnt_c = 1'b1;
            spush_c = 1'b1;
          end
        end
      end
      ST_RD: begin
        state_d = ST_FETCH;
        if (!supp_q) begin
          srp_c = 1'b1;
        end
      end
      ST_FETCH: begin
        state_d = ST_IDLE;
        if (!supp_q) begin
          fetch_c = 1'b1;
          case (op_q)
            OP_PUSH: begin
              spcnt_c = 1'b1;
              spush_c = 1'b1;
              dep_inc = 1'b1;
            end
            OP_POP: begin
              spcnt_c  = 1'b1;
              dep_dec  = 1'b1;
              rsp_fire = 1'b1;
            end
            OP_PEEK: begin
              rsp_fire = 1'b1;
            end
            default: begin
            end
          endcase
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset is synchronous, so gate the decoded strobes with it to keep the
  // reset cycle itself free of stack activity.
  assign bus.cmd_ready = ready_c && !reset;
  assign bus.spc_spcnt = spcnt_c && !reset;
  assign bus.spc_spush = spush_c && !reset;
  assign bus.spc_srp   = srp_c   && !reset;
  assign bus.spc_swp   = swp_c   && !reset;
  assign bus.spc_fetch = fetch_c && !reset;
  assign bus.spc_wdata = wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

`ifdef SPC_TRAP_EN
  assign trap_ovf = !reset && (state_q == ST_FETCH) && supp_q && (op_q == OP_PUSH);
  assign trap_unf = !reset && (state_q == ST_FETCH) && supp_q && op_is_read(op_q);
`else
  assign trap_ovf = 1'b0;
  assign trap_unf = 1'b0;
`endif

  spc_depth_ctr #(
    .AW (AW)
  ) u_depth (
    .clk   (clk),
    .reset (reset),
    .inc   (dep_inc),
    .dec   (dep_dec),
    .depth (depth),
    .empty (empty),
    .full  (full)
  );

  a_no_rw_collision: assert property (@(posedge clk) disable iff (reset)
    !(bus.spc_srp && bus.spc_swp));

  a_idle_quiet: assert property (@(posedge clk) disable iff (reset)
    bus.cmd_ready |-> !(bus.spc_srp || bus.spc_swp || bus.spc_fetch || bus.spc_spcnt));

endmodule

// File: tb/tb_spc_stack_ctl.sv
// Directed bench for spc_stack_ctl paired with a behavioural SPC stack block.
// Trap scenario is built when SPC_TRAP_EN is defined, wrap scenario otherwise.
module tb_spc_stack_ctl;
  import spc_pkg::*;

  localparam int DW = SPC_DW;
  localparam int AW = SPC_AW;

  logic        clk = 1'b0;
  logic        reset;
  logic [AW:0] depth;
  logic        empty;
  logic        full;
  logic        trap_ovf;
  logic        trap_unf;
  int          passed = 0;
  int          total = 0;

  spc_stack_ctl_if #(.DW(DW)) bus ();

  spc_stack_ctl #(.DW(DW), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .depth    (depth),
    .empty    (empty),
    .full     (full),
    .trap_ovf (trap_ovf),
    .trap_unf (trap_unf)
  );

  always #5 clk = ~clk;

  // Stack block: write at ptr+1 when spcnt (push) else at ptr; registered read of ptr.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] sp;
  logic [AW-1:0] wp;
  logic [DW-1:0] rdata_q;

  assign wp = bus.spc_spcnt ? sp + 1'b1 : sp;
  assign bus.spc_rdata = rdata_q;

  always @(posedge clk) begin
    if (reset) begin
      sp      <= '0;
      rdata_q <= '0;
    end else begin
      if (bus.spc_swp) mem[wp] <= bus.spc_wdata;
      if (bus.spc_srp) rdata_q <= mem[sp];
      if (bus.spc_fetch && bus.spc_spcnt) sp <= bus.spc_spush ? sp + 1'b1 : sp - 1'b1;
    end
  end

  function automatic logic [4:0] stb();
    return {bus.spc_spcnt, bus.spc_spush, bus.spc_srp, bus.spc_swp, bus.spc_fetch};
  endfunction

  // Called at a negedge while the controller is idle; returns at the negedge of the ACC cycle.
  task automatic drive_cmd(input logic [1:0] op, input logic [DW-1:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = '0;
    repeat (2) @(negedge clk);
    total++; if (stb() !== 5'b0) $display("[TB] FAIL reset_strobes: got %b want 00000", stb()); else passed++;
    reset = 1'b0;
    #1;
    total++; if (bus.cmd_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b want 1", bus.cmd_ready); else passed++;
    total++; if (depth !== 6'd0) $display("[TB] FAIL reset_depth: got %0d want 0", depth); else passed++;
    total++; if (empty !== 1'b1 || full !== 1'b0) $display("[TB] FAIL reset_flags: got empty=%b full=%b want 1/0", empty, full); else passed++;
    total++; if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== '0) $display("[TB] FAIL reset_rsp: got %b/%h want 0/0", bus.rsp_valid, bus.rsp_data); else passed++;
    total++; if (bus.spc_wdata !== '0) $display("[TB] FAIL reset_wdata: got %h want 0", bus.spc_wdata); else passed++;
    total++; if (trap_ovf !== 1'b0 || trap_unf !== 1'b0) $display("[TB] FAIL reset_traps: got %b%b want 00", trap_ovf, trap_unf); else passed++;
  endtask

  task automatic test_push_pop();
    @(negedge clk);
    drive_cmd(OP_PUSH, 19'h12345);
    total++; if (stb() !== 5'b11010) $display("[TB] FAIL t1_push_wr: got %b want 11010", stb()); else passed++;
    total++; if (bus.spc_wdata !== 19'h12345) $display("[TB] FAIL t1_wdata: got %h want 12345", bus.spc_wdata); else passed++;
    total++; if (bus.cmd_ready !== 1'b0) $display("[TB] FAIL t1_ready_wr: got %b want 0", bus.cmd_ready); else passed++;
    @(negedge clk);
    total++; if (stb() !== 5'b11001) $display("[TB] FAIL t1_push_fetch: got %b want 11001", stb()); else passed++;
    @(negedge clk);
    total++; if (stb() !== 5'b00000) $display("[TB] FAIL t1_idle_strobes: got %b want 00000", stb()); else passed++;
    total++; if (depth !== 6'd1) $display("[TB] FAIL t1_depth_push: got %0d want 1", depth); else passed++;
    drive_cmd(OP_POP, '0);
    total++; if (stb() !== 5'b00100) $display("[TB] FAIL t1_pop_rd: got %b want 00100", stb()); else passed++;
    @(negedge clk);
    total++; if (stb() !== 5'b10001) $display("[TB] FAIL t1_pop_fetch: got %b want 10001", stb()); else passed++;
    total++; if (bus.rsp_valid !== 1'b0) $display("[TB] FAIL t1_rsp_early: got %b want 0", bus.rsp_valid); else passed++;
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 19'h12345) $display("[TB] FAIL t1_pop_rsp: got %b/%h want 1/12345", bus.rsp_valid, bus.rsp_data); else passed++;
    total++; if (depth !== 6'd0 || empty !== 1'b1) $display("[TB] FAIL t1_depth_pop: got %0d/%b want 0/1", depth, empty); else passed++;
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b0) $display("[TB] FAIL t1_rsp_pulse: got %b want 0", bus.rsp_valid); else passed++;
  endtask

  task automatic test_lifo_order();
    for (int i = 1; i <= 3; i++) begin
      drive_cmd(OP_PUSH, DW'(i));
      total++; if (bus.cmd_ready !== 1'b0) $display("[TB] FAIL t2_ready_acc: got %b want 0", bus.cmd_ready); else passed++;
      @(negedge clk);
      total++; if (bus.cmd_ready !== 1'b0) $display("[TB] FAIL t2_ready_fetch: got %b want 0", bus.cmd_ready); else passed++;
      @(negedge clk);
      total++; if (bus.cmd_ready !== 1'b1) $display("[TB] FAIL t2_ready_idle: got %b want 1", bus.cmd_ready); else passed++;
    end
    total++; if (depth !== 6'd3) $display("[TB] FAIL t2_depth3: got %0d want 3", depth); else passed++;
    for (int i = 0; i < 3; i++) begin
      drive_cmd(OP_POP, '0);
      repeat (2) @(negedge clk);
      total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== DW'(3 - i)) $display("[TB] FAIL t2_pop_order: got %b/%h want 1/%h", bus.rsp_valid, bus.rsp_data, DW'(3 - i)); else passed++;
    end
    total++; if (empty !== 1'b1) $display("[TB] FAIL t2_empty: got %b want 1", empty); else passed++;
  endtask

  task automatic test_peek_replace();
    drive_cmd(OP_PUSH, 19'h7);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      drive_cmd(OP_PEEK, '0);
      total++; if (stb() !== 5'b00100) $display("[TB] FAIL t3_peek_rd: got %b want 00100", stb()); else passed++;
      @(negedge clk);
      total++; if (stb() !== 5'b00001) $display("[TB] FAIL t3_peek_fetch: got %b want 00001", stb()); else passed++;
      @(negedge clk);
      total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 19'h7) $display("[TB] FAIL t3_peek_rsp: got %b/%h want 1/7", bus.rsp_valid, bus.rsp_data); else passed++;
      total++; if (depth !== 6'd1) $display("[TB] FAIL t3_peek_depth: got %0d want 1", depth); else passed++;
    end
    drive_cmd(OP_REPLACE, 19'h9);
    total++; if (stb() !== 5'b00010 || bus.spc_wdata !== 19'h9) $display("[TB] FAIL t3_repl_wr: got %b/%h want 00010/9", stb(), bus.spc_wdata); else passed++;
    @(negedge clk);
    total++; if (stb() !== 5'b00001) $display("[TB] FAIL t3_repl_fetch: got %b want 00001", stb()); else passed++;
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b0 || depth !== 6'd1) $display("[TB] FAIL t3_repl_norsp: got %b/%0d want 0/1", bus.rsp_valid, depth); else passed++;
    drive_cmd(OP_POP, '0);
    repeat (2) @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 19'h9) $display("[TB] FAIL t3_pop_repl: got %b/%h want 1/9", bus.rsp_valid, bus.rsp_data); else passed++;
    total++; if (depth !== 6'd0) $display("[TB] FAIL t3_depth_end: got %0d want 0", depth); else passed++;
  endtask

`ifdef SPC_TRAP_EN
  task automatic test_traps();
    logic [4:0] seen;
    pulse_reset();
    for (int i = 1; i <= 32; i++) begin
      drive_cmd(OP_PUSH, DW'(i));
      repeat (2) @(negedge clk);
    end
    total++; if (full !== 1'b1 || depth !== 6'd32) $display("[TB] FAIL t4_full: got %b/%0d want 1/32", full, depth); else passed++;
    drive_cmd(OP_PUSH, 19'h55);
    total++; if (stb() !== 5'b00000) $display("[TB] FAIL t4_ovf_wr: got %b want 00000", stb()); else passed++;
    @(negedge clk);
    total++; if (trap_ovf !== 1'b1 || stb() !== 5'b00000) $display("[TB] FAIL t4_ovf_fetch: got %b/%b want 1/00000", trap_ovf, stb()); else passed++;
    @(negedge clk);
    total++; if (trap_ovf !== 1'b0 || depth !== 6'd32) $display("[TB] FAIL t4_ovf_after: got %b/%0d want 0/32", trap_ovf, depth); else passed++;
    for (int i = 0; i < 32; i++) begin
      drive_cmd(OP_POP, '0);
      repeat (2) @(negedge clk);
    end
    total++; if (bus.rsp_data !== 19'h1 || empty !== 1'b1) $display("[TB] FAIL t4_drain: got %h/%b want 1/1", bus.rsp_data, empty); else passed++;
    drive_cmd(OP_POP, '0);
    seen = stb();
    @(negedge clk);
    total++; if (trap_unf !== 1'b1 || (seen | stb()) !== 5'b00000) $display("[TB] FAIL t4_unf: got %b/%b want 1/00000", trap_unf, seen | stb()); else passed++;
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b0 || trap_unf !== 1'b0 || depth !== 6'd0) $display("[TB] FAIL t4_unf_after: got %b/%b/%0d want 0/0/0", bus.rsp_valid, trap_unf, depth); else passed++;
  endtask
`else
  task automatic test_wrap();
    logic traps_seen;
    traps_seen = 1'b0;
    for (int i = 1; i <= 33; i++) begin
      drive_cmd(OP_PUSH, DW'(i));
      traps_seen |= trap_ovf | trap_unf;
      @(negedge clk);
      traps_seen |= trap_ovf | trap_unf;
      @(negedge clk);
      traps_seen |= trap_ovf | trap_unf;
      if (i == 32) begin
        total++; if (full !== 1'b1 || depth !== 6'd32) $display("[TB] FAIL t5_full: got %b/%0d want 1/32", full, depth); else passed++;
      end
    end
    total++; if (depth !== 6'd32) $display("[TB] FAIL t5_sat: got %0d want 32", depth); else passed++;
    drive_cmd(OP_POP, '0);
    repeat (2) @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 19'd33) $display("[TB] FAIL t5_pop33: got %b/%h want 1/21", bus.rsp_valid, bus.rsp_data); else passed++;
    total++; if (depth !== 6'd31) $display("[TB] FAIL t5_depth31: got %0d want 31", depth); else passed++;
    total++; if (traps_seen !== 1'b0) $display("[TB] FAIL t5_traps: got %b want 0", traps_seen); else passed++;
  endtask
`endif

  task automatic test_reset_midflight();
    pulse_reset();
    drive_cmd(OP_PUSH, 19'h5);
    repeat (2) @(negedge clk);
    drive_cmd(OP_POP, '0);
    reset = 1'b1;
    #1;
    total++; if (stb() !== 5'b00000) $display("[TB] FAIL t6_strobes_rst: got %b want 00000", stb()); else passed++;
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b0 || stb() !== 5'b00000) $display("[TB] FAIL t6_after_rst: got %b/%b want 0/00000", bus.rsp_valid, stb()); else passed++;
    reset = 1'b0;
    #1;
    total++; if (bus.cmd_ready !== 1'b1) $display("[TB] FAIL t6_ready: got %b want 1", bus.cmd_ready); else passed++;
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b0 || depth !== 6'd0 || stb() !== 5'b00000) $display("[TB] FAIL t6_quiet: got %b/%0d/%b want 0/0/00000", bus.rsp_valid, depth, stb()); else passed++;
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_lifo_order();
    test_peek_replace();
`ifdef SPC_TRAP_EN
    test_traps();
`else
    test_wrap();
`endif
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
